// File: rtl/conv_sched.sv
// conv_sched: shares one external two-operand datapath (signed 8-bit operands,
// signed 9-bit result, fixed latency DP_LAT) among N requesters.
//
// Sequence: arbitrate in IDLE, pulse dp_start in ISSUE, count DP_LAT in WAIT,
// then present the captured result tagged with the owner ID in RESP.
//
// Configuration macro: CONV_SCHED_FIXED_PRIO_EN
//   defined     -> fixed priority, the lowest asserted index wins (no pointer)
//   not defined -> round-robin, with the pointer advancing past each winner
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   req_valid  in   [N]    per-requester request
//   req_data0  in   [8*N]  operand A, slice i = [8*i+7:8*i]
//   req_data1  in   [8*N]  operand B, same slicing
//   req_ready  out  [N]    one-hot accept (combinational, IDLE only)
//   dp_start   out         one-cycle issue pulse to the datapath
//   dp_a/dp_b  out  [8]    operands to the datapath
//   dp_result  in   [9]    datapath result
//   rsp_valid  out         response valid
//   rsp_id     out  [3]    owner of the response
//   rsp_data   out  [9]    captured result
//   rsp_ready  in          response consumer accepts
//   busy       out         registered, high whenever state != IDLE
//
// State table:
//   state  | meaning
//   IDLE   | arbitrate; accept one request and latch its operands
//   ISSUE  | dp_start high; load latency counter with DP_LAT-1
//   WAIT   | count down; capture dp_result when the counter reaches 0
//   RESP   | hold rsp_valid until rsp_ready
module conv_sched #(
  parameter int N      = 4,
  parameter int DP_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data0,
  input  logic [8*N-1:0] req_data1,
  output logic [N-1:0]   req_ready,
  output logic           dp_start,
  output logic [7:0]     dp_a,
  output logic [7:0]     dp_b,
  input  logic [8:0]     dp_result,
  output logic           rsp_valid,
  output logic [2:0]     rsp_id,
  output logic [8:0]     rsp_data,
  input  logic           rsp_ready,
  output logic           busy
);

  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dp_start_q, dp_start_d;
  logic [7:0]  dp_a_q, dp_a_d;
  logic [7:0]  dp_b_q, dp_b_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_id_q, rsp_id_d;
  logic [8:0]  rsp_data_q, rsp_data_d;
  logic        busy_q, busy_d;

  logic          any_req;
  logic [IW-1:0] win;
  logic [N-1:0]  grant_vec;

`ifdef CONV_SCHED_FIXED_PRIO_EN
  // Scan from the top down so the lowest asserted index is the last written.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        any_req = 1'b1;
        win     = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   idx;

  // Search p, p+1, ..., N-1, 0, ..., p-1; the first asserted request wins.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + IW1'(k);
      if (idx >= IW1'(N)) idx = idx - IW1'(N);
      if (!any_req && req_valid[idx[IW-1:0]]) begin
        any_req = 1'b1;
        win     = idx[IW-1:0];
      end
    end
  end
`endif

  always_comb begin
    grant_vec      = '0;
    grant_vec[win] = 1'b1;
  end

  assign req_ready = (state_q == S_IDLE && any_req) ? grant_vec : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_start_d  = 1'b0;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifndef CONV_SCHED_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d    = S_ISSUE;
          dp_start_d = 1'b1;
          dp_a_d     = req_data0[8*win +: 8];
          dp_b_d     = req_data1[8*win +: 8];
          rsp_id_d   = 3'(win);
`ifndef CONV_SCHED_FIXED_PRIO_EN
          ptr_d      = (win == IW'(N - 1)) ? '0 : win + IW'(1);
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = 4'(DP_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = dp_result;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dp_start_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifndef CONV_SCHED_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_start_q  <= dp_start_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifndef CONV_SCHED_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign dp_start  = dp_start_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed bench for conv_sched (N=4, DP_LAT=2) with a
// pipelined datapath model computing A-B; it yields a marker value whenever
// it is sampled at the wrong time.
module tb_conv_sched;
  localparam int N      = 4;
  localparam int DP_LAT = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data0;
  logic [8*N-1:0] req_data1;
  logic [N-1:0]   req_ready;
  logic           dp_start;
  logic [7:0]     dp_a;
  logic [7:0]     dp_b;
  logic [8:0]     dp_result;
  logic           rsp_valid;
  logic [2:0]     rsp_id;
  logic [8:0]     rsp_data;
  logic           rsp_ready;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  conv_sched #(.N(N), .DP_LAT(DP_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .dp_start  (dp_start),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_result (dp_result),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [8:0] pipe [DP_LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= dp_start ? ({dp_a[7], dp_a} - {dp_b[7], dp_b}) : 9'h0AA;
    for (int k = 1; k < DP_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign dp_result = pipe[DP_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, " dp_start"},  32'(dp_start),  32'h0);
    chk({tag, " busy"},      32'(busy),      32'h0);
    chk({tag, " dp_a"},      32'(dp_a),      32'h0);
    chk({tag, " dp_b"},      32'(dp_b),      32'h0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, " rsp_id"},    32'(rsp_id),    32'h0);
    chk({tag, " rsp_data"},  32'(rsp_data),  32'h0);
  endtask

  // One transaction from requester idx with rsp_ready asserted at the response.
  task automatic do_txn(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] exp);
    logic [N-1:0] v;
    int n;
    v = '0;
    v[idx] = 1'b1;
    req_valid = v;
    req_data0[8*idx +: 8] = a;
    req_data1[8*idx +: 8] = b;
    #1;
    chk("txn req_ready", 32'(req_ready), 32'(v));
    @(negedge clk);
    req_valid = '0;
    chk("txn dp_start", 32'(dp_start), 32'h1);
    chk("txn dp_a", 32'(dp_a), 32'(a));
    chk("txn dp_b", 32'(dp_b), 32'(b));
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("txn latency", 32'(n), 32'(DP_LAT + 2));
    chk("txn rsp_id", 32'(rsp_id), 32'(idx));
    chk("txn rsp_data", 32'(rsp_data), 32'(exp));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("txn back to idle", 32'(busy), 32'h0);
    rsp_ready = 1'b0;
  endtask

  logic [N-1:0] gv [5];
  int           gc [5];
  logic [N-1:0] exp_g [5];
  int           ng;
  int           n;
  logic         saw;

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data0 = '0;
    req_data1 = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // Single request from requester 2: A=10, B=-5 -> 15, response at T+4.
    @(negedge clk);
    req_valid = 4'b0100;
    req_data0[23:16] = 8'd10;
    req_data1[23:16] = 8'hFB;
    #1;
    chk("single req_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single dp_start T+1", 32'(dp_start), 32'h1);
    chk("single dp_a", 32'(dp_a), 32'h0A);
    chk("single dp_b", 32'(dp_b), 32'hFB);
    chk("single busy", 32'(busy), 32'h1);
    chk("single req_ready busy", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("single dp_start T+2", 32'(dp_start), 32'h0);
    chk("single rsp_valid T+2", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("single rsp_valid T+3", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("single rsp_valid T+4", 32'(rsp_valid), 32'h1);
    chk("single rsp_id", 32'(rsp_id), 32'h2);
    chk("single rsp_data", 32'(rsp_data), 32'h00F);

    // Backpressure: ten stalled cycles in RESP with another request pending.
    req_valid = 4'b0001;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("stall req_ready", 32'(req_ready), 32'h0);
      chk("stall rsp_valid", 32'(rsp_valid), 32'h1);
      chk("stall rsp_id", 32'(rsp_id), 32'h2);
      chk("stall rsp_data", 32'(rsp_data), 32'h00F);
      chk("stall busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release busy", 32'(busy), 32'h0);
    chk("release rsp_valid", 32'(rsp_valid), 32'h0);
    chk("release dp_a held", 32'(dp_a), 32'h0A);
    chk("release req_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    rsp_ready = 1'b0;

    // Operand extremes through requester 3.
    do_txn(3, 8'h80, 8'h7F, 9'h101);
    do_txn(3, 8'h7F, 8'h80, 9'h0FF);

    // All four requesters held valid with rsp_ready high.
`ifdef CONV_SCHED_FIXED_PRIO_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001;
    exp_g[3] = 4'b0001; exp_g[4] = 4'b0001;
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
`endif
    rsp_ready = 1'b1;
    req_data0 = 32'h03020100;
    req_data1 = 32'h0;
    req_valid = 4'hF;
    ng = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (req_ready != '0 && ng < 5) begin
        gv[ng] = req_ready;
        gc[ng] = cyc;
        ng++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr grant count", 32'(ng), 32'd5);
    for (int g = 0; g < 5; g++) begin
      if (g < ng) begin
        chk("rr grant", 32'(gv[g]), 32'(exp_g[g]));
        if (g > 0) chk("rr spacing", 32'(gc[g] - gc[g-1]), 32'(DP_LAT + 3));
      end
    end
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain busy", 32'(busy), 32'h0);

    // Reset while in WAIT aborts the transaction.
    req_valid = 4'b0010;
    req_data0[15:8] = 8'd5;
    req_data1[15:8] = 8'd1;
    #1;
    chk("abort req_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("abort in wait busy", 32'(busy), 32'h1);
    chk("abort in wait rsp_valid", 32'(rsp_valid), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    reset = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw = 1'b1;
    end
    chk("abort no response", 32'(saw), 32'h0);
    req_valid = 4'hF;
    #1;
    chk("abort next grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
